// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// bit-period computation and the even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per serial bit (integer division, remainder dropped).
  function automatic int unsigned calc_bit_cyc(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_buf_fifo.sv
// sync_fifo: single-clock FIFO with an extra pointer bit to tell full from
// empty. A write while full is ignored; a read while empty is ignored.
// rd_data shows the head entry whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign rd_data = mem[rd_ptr_r[AW-1:0]];

  // Pointer update; the natural wrap of the AW+1 bit pointers gives modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO in front of an 8N1 UART transmitter.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11-bit frame).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned BAUD       = 32'd9600,
  parameter int unsigned FIFO_DEPTH = 32'd16
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       tx_flag,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
  localparam int unsigned CW      = (BIT_CYC > 32'd1) ? $clog2(BIT_CYC) : 32'd1;
  localparam logic [CW-1:0] RELOAD  = CW'(BIT_CYC - 32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  tx_state_t   state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [2:0]  bit_idx_r, idx_nxt;
  logic [7:0]  shift_r, shift_nxt;
  logic        tx_r, tx_nxt;
  logic        busy_r;
  logic        overflow_r;
  logic        pop_s;
  logic        bit_done_s;
  logic        full_s;
  logic        empty_s;
  logic [7:0]  rd_data_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (rst_n),
    .wr_en   (tx_flag),
    .wr_data (tx_data),
    .rd_en   (pop_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign bit_done_s = (cnt_r == '0);
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_full  = full_s;
  assign overflow   = overflow_r;

  // Next-state, bit counter, bit index and FIFO pop decisions.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    idx_nxt   = bit_idx_r;
    shift_nxt = shift_r;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          shift_nxt = rd_data_s;
          cnt_nxt   = RELOAD;
          state_nxt = START;
        end else begin
          cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_done_s) begin
          cnt_nxt   = RELOAD;
          idx_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          cnt_nxt = RELOAD;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          cnt_nxt   = RELOAD;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_done_s) begin
          if (!empty_s) begin
            // Chain the next frame straight from the stop bit, no idle gap.
            pop_s     = 1'b1;
            shift_nxt = rd_data_s;
            cnt_nxt   = RELOAD;
            state_nxt = START;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_r)
      IDLE:  tx_nxt = 1'b1;
      START: tx_nxt = 1'b0;
      DATA:  tx_nxt = shift_r[bit_idx_r];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = even_parity(shift_r);
`endif
      STOP:  tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  // FSM registers and registered outputs; reset aborts any frame at once.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bit_idx_r <= idx_nxt;
      shift_r   <= shift_nxt;
      tx_r      <= tx_nxt;
      busy_r    <= (state_r != IDLE) || !empty_s;
      if (tx_flag && full_s) overflow_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
module tb_uart_tx_buf;

  localparam int BIT = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_flag = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, busy, fifo_full, overflow;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // line monitor results
  logic [7:0] rx_q[$];
  logic       par_q[$];
  int         start_q[$];
  int         frame_err = 0;

  uart_tx_buf #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .tx_flag   (tx_flag),
    .tx_data   (tx_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // Independent serial receiver sampling mid-bit on the falling edge.
  initial begin : monitor
    bit               m_act;
    int               m_idx;
    int               m_t0;
    logic [NBITS-1:0] m_bits;
    m_act = 1'b0;
    m_idx = 0;
    m_t0  = 0;
    m_bits = '0;
    forever begin
      @(negedge sclk);
      if (rst_n !== 1'b1) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (tx === 1'b0) begin
          m_act = 1'b1;
          m_idx = 0;
          m_t0  = cyc;
        end
      end else begin
        m_idx++;
        if (m_idx % BIT == 5) m_bits[m_idx / BIT] = tx;
        if (m_idx == (NBITS - 1) * BIT + 5) begin
          if (m_bits[0] !== 1'b0) frame_err++;
          if (m_bits[NBITS-1] !== 1'b1) frame_err++;
`ifdef UART_TX_PARITY_EN
          if (m_bits[9] !== ^m_bits[8:1]) frame_err++;
          par_q.push_back(m_bits[9]);
`endif
          rx_q.push_back(m_bits[8:1]);
          start_q.push_back(m_t0);
          m_act = 1'b0;
        end
      end
    end
  end

  function automatic logic line_bit(input logic [7:0] d, input int j);
    int k;
    k = j / BIT;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called at posedge+1; presents a byte for the next edge and returns at that edge+1.
  task automatic strobe(input logic [7:0] d);
    tx_flag = 1'b1;
    tx_data = d;
    @(posedge sclk);
    #1;
    tx_flag = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    repeat (3) @(posedge sclk);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sclk);
      #1;
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    par_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int errs;
    int first_j;
    logic first_v;
    logic [7:0] d;
    d = 8'hA5;
    errs = 0;
    first_j = -1;
    first_v = 1'b0;
    clear_mon();
    @(posedge sclk);
    #1;
    strobe(d);                       // edge N, now N+1ns
    checks++; if (tx !== 1'b1) $display("FAIL single_tx_at_N: got %b want 1", tx); else passed++;
    @(posedge sclk); #1;             // after N+1
    checks++; if (tx !== 1'b1) $display("FAIL single_tx_at_N1: got %b want 1", tx); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_at_N1: got %b want 1", busy); else passed++;
    for (int j = 0; j < FRAME; j++) begin
      @(posedge sclk); #1;           // after N+2+j
      if (tx !== line_bit(d, j)) begin
        errs++;
        if (first_j < 0) begin
          first_j = j;
          first_v = tx;
        end
      end
    end
    checks++;
    if (errs != 0) $display("FAIL single_waveform: %0d wrong cycles, first at offset %0d got %b want %b",
                            errs, first_j, first_v, line_bit(d, first_j));
    else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_in_stop: got %b want 1", busy); else passed++;
    @(posedge sclk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_after_stop: got %b want 0", busy); else passed++;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL single_rx: got %0d bytes first %h want 1 byte a5",
                                                        rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [7:0] exp [3];
    exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
    clear_mon();
    strobe(exp[0]);
    strobe(exp[1]);
    strobe(exp[2]);
    wait_idle(1000, to);
    checks++; if (to) $display("FAIL b2b_timeout: busy still %b want 0", busy); else passed++;
    checks++; if (rx_q.size() != 3) $display("FAIL b2b_count: got %0d want 3", rx_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i])
        $display("FAIL b2b_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
      else passed++;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= start_q.size() || start_q[i] - start_q[i-1] != FRAME)
        $display("FAIL b2b_gap%0d: got %0d want %0d", i,
                 (i < start_q.size()) ? start_q[i] - start_q[i-1] : -1, FRAME);
      else passed++;
    end
    checks++; if (frame_err != 0) $display("FAIL b2b_framing: got %0d errors want 0", frame_err); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    clear_mon();
    strobe(8'h00);                   // edge N
    strobe(8'h77);                   // edge N+1, stays buffered
    repeat (45) @(posedge sclk);     // after edge N+46: data bit 3 of first frame
    #1;
    checks++; if (tx !== 1'b0) $display("FAIL rstmid_pre_tx: got %b want 0", tx); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    checks++; if (fifo_full !== 1'b0) $display("FAIL rstmid_full: got %b want 0", fifo_full); else passed++;
    repeat (3) @(posedge sclk);
    #1;
    rst_n = 1'b1;
    strobe(8'h3C);                   // first edge after release
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy_pre: got %b want 0", busy); else passed++;
    @(posedge sclk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_accept: busy got %b want 1", busy); else passed++;
    wait_idle(400, to);
    checks++; if (to) $display("FAIL rstmid_timeout: busy still %b want 0", busy); else passed++;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) $display("FAIL rstmid_rx: got %0d bytes first %h want 1 byte 3c",
                                                        rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else passed++;
    checks++; if (frame_err != 0) $display("FAIL rstmid_framing: got %0d errors want 0", frame_err); else passed++;
  endtask

  task automatic test_stream();
    bit to;
    int full_seen;
    int bad;
    logic [7:0] sent [30];
    full_seen = 0;
    bad = 0;
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      sent[i] = 8'((i * 37 + 11) % 256);
      strobe(sent[i]);
      for (int c = 0; c < FRAME + 9; c++) begin
        @(posedge sclk); #1;
        if (fifo_full !== 1'b0) full_seen++;
      end
    end
    wait_idle(500, to);
    checks++; if (to) $display("FAIL stream_timeout: busy still %b want 0", busy); else passed++;
    checks++; if (full_seen != 0) $display("FAIL stream_full: seen %0d cycles want 0", full_seen); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL stream_overflow: got %b want 0", overflow); else passed++;
    checks++; if (rx_q.size() != 30) $display("FAIL stream_count: got %0d want 30", rx_q.size()); else passed++;
    for (int i = 0; i < 30 && i < rx_q.size(); i++) if (rx_q[i] !== sent[i]) bad++;
    checks++; if (bad != 0) $display("FAIL stream_data: got %0d wrong bytes want 0", bad); else passed++;
    checks++; if (frame_err != 0) $display("FAIL stream_framing: got %0d errors want 0", frame_err); else passed++;
  endtask

  task automatic test_full_overflow();
    bit to;
    int bad;
    bad = 0;
    clear_mon();
    for (int k = 1; k <= 18; k++) begin
      strobe(8'(8'h40 + k));
      if (k == 16) begin
        checks++; if (fifo_full !== 1'b0) $display("FAIL full_after16: got %b want 0", fifo_full); else passed++;
      end
      if (k == 17) begin
        checks++; if (fifo_full !== 1'b1) $display("FAIL full_after17: got %b want 1", fifo_full); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_after17: got %b want 0", overflow); else passed++;
      end
    end
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_after18: got %b want 1", overflow); else passed++;
    checks++; if (fifo_full !== 1'b1) $display("FAIL full_after18: got %b want 1", fifo_full); else passed++;
    wait_idle(17 * FRAME + 300, to);
    checks++; if (to) $display("FAIL full_timeout: busy still %b want 0", busy); else passed++;
    checks++; if (rx_q.size() != 17) $display("FAIL full_count: got %0d want 17", rx_q.size()); else passed++;
    for (int i = 0; i < 17 && i < rx_q.size(); i++) if (rx_q[i] !== 8'(8'h41 + i)) bad++;
    checks++; if (bad != 0) $display("FAIL full_data: got %0d wrong bytes want 0", bad); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
    checks++; if (fifo_full !== 1'b0) $display("FAIL full_drained: got %b want 0", fifo_full); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_reset: got %b want 0", overflow); else passed++;
    @(posedge sclk); #1;
    rst_n = 1'b1;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    clear_mon();
    strobe(8'h07);
    strobe(8'h03);
    wait_idle(600, to);
    checks++; if (to) $display("FAIL par_timeout: busy still %b want 0", busy); else passed++;
    checks++;
    if (par_q.size() != 2 || par_q[0] !== 1'b1) $display("FAIL par_07: got %0d frames bit %b want 1",
                                                         par_q.size(), (par_q.size() > 0) ? par_q[0] : 1'bx);
    else passed++;
    checks++;
    if (par_q.size() != 2 || par_q[1] !== 1'b0) $display("FAIL par_03: got %0d frames bit %b want 0",
                                                         par_q.size(), (par_q.size() > 1) ? par_q[1] : 1'bx);
    else passed++;
    checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 110)
      $display("FAIL par_frame_len: got %0d want 110", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stream();
    test_full_overflow();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
